// File: rtl/mips_multi_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_multi_ctrl_if
//   Bundle between the multicycle MIPS main controller and its datapath.
//   master : controller side (samples opcode/zero/mem_ready, drives controls)
//   slave  : datapath side   (drives opcode/zero/mem_ready, samples controls)
//
//   opcode     instruction[31:26] from the IR
//   zero       ALU zero flag
//   mem_ready  memory completes the current access this cycle
//   pc_en      PC enable = pc_write | (branch & zero)
//   ir_write   IR enable
//   mem_write  memory write strobe
//   reg_write  register-file write enable
//   iord       address mux: 0 = PC, 1 = ALUOut
//   mem_to_reg write-back data: 0 = ALUOut, 1 = MDR
//   reg_dst    write register: 0 = rt, 1 = rd
//   alu_src_a  0 = PC, 1 = A
//   alu_src_b  00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op     00 = add, 01 = sub, 10 = funct-decoded
//   pc_src     00 = ALU result, 01 = ALUOut, 10 = jump target
//   illegal_op one-cycle pulse on an unknown opcode in DECODE
//   state      current controller state (debug)
// -----------------------------------------------------------------------------
interface mips_multi_ctrl_if #(
  parameter int OPW = 6,
  parameter int SW  = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;

  logic           pc_en;
  logic           ir_write;
  logic           mem_write;
  logic           reg_write;
  logic           iord;
  logic           mem_to_reg;
  logic           reg_dst;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic [1:0]     pc_src;
  logic           illegal_op;
  logic [SW-1:0]  state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );
endinterface

// File: rtl/mips_multi_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multi_ctrl
//   Moore main control FSM for the multicycle MIPS datapath. Sequences each
//   instruction through fetch / decode / execute / memory / write-back,
//   stretching FETCH, MEMRD and MEMWR until mem_ready.
//
//   clk    rising-edge clock
//   reset  asynchronous, active-high; forces FETCH and zeroes every output
//   bus    mips_multi_ctrl_if.master (opcode/zero/mem_ready in, controls out)
// -----------------------------------------------------------------------------
module mips_multi_ctrl #(
  parameter int OPW = 6,
  parameter int SW  = 4
) (
  input  logic              clk,
  input  logic              reset,
  mips_multi_ctrl_if.master bus
);

  typedef enum logic [SW-1:0] {
    S_FETCH   = SW'(0),
    S_DECODE  = SW'(1),
    S_MEMADR  = SW'(2),
    S_MEMRD   = SW'(3),
    S_MEMWB   = SW'(4),
    S_MEMWR   = SW'(5),
    S_EXECUTE = SW'(6),
    S_ALUWB   = SW'(7),
    S_BRANCH  = SW'(8),
    S_ADDIEX  = SW'(9),
    S_ADDIWB  = SW'(10),
    S_JUMP    = SW'(11)
  } state_e;

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  state_e     r_state;
  state_e     w_next;

  logic       w_pc_write;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_iord;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_src;
  logic       w_illegal;

  // State register: the only storage in the block.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state and Moore output decode.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next       = S_FETCH;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_iord       = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_src     = 2'b00;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 through the ALU; IR and PC load together when memory is ready.
        w_alu_src_b = 2'b01;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
        w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        w_alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        // Strobe stays up for every wait cycle of the store.
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_branch    = 1'b1;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH; // unused encodings recover, outputs stay 0
    endcase
  end

  // Outputs are gated by reset so enables drop the instant reset rises,
  // independent of the state register's clear-to-FETCH (FETCH itself drives
  // nonzero selects and a mem_ready-qualified IR/PC load).
  assign bus.pc_en      = ~reset & (w_pc_write | (w_branch & bus.zero));
  assign bus.ir_write   = ~reset & w_ir_write;
  assign bus.mem_write  = ~reset & w_mem_write;
  assign bus.reg_write  = ~reset & w_reg_write;
  assign bus.iord       = ~reset & w_iord;
  assign bus.mem_to_reg = ~reset & w_mem_to_reg;
  assign bus.reg_dst    = ~reset & w_reg_dst;
  assign bus.alu_src_a  = ~reset & w_alu_src_a;
  assign bus.alu_src_b  = reset ? 2'b00 : w_alu_src_b;
  assign bus.alu_op     = reset ? 2'b00 : w_alu_op;
  assign bus.pc_src     = reset ? 2'b00 : w_pc_src;
  assign bus.illegal_op = ~reset & w_illegal;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
module tb_mips_multi_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } out_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multi_ctrl_if #(.OPW(6), .SW(4)) bus ();

  mips_multi_ctrl #(.OPW(6), .SW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference outputs from the state table; the expected state itself comes
  // from each test's own sequence, not from this function.
  function automatic out_t model(input logic [3:0] st, input logic [5:0] op,
                                 input logic z, input logic mr, input logic rst);
    out_t e;
    e = '0;
    if (rst) return e;
    e.st = st;
    case (st)
      4'd0:  begin e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      4'd1:  begin
        e.alu_src_b  = 2'b11;
        e.illegal_op = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      end
      4'd2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      4'd3:  e.iord = 1'b1;
      4'd4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      4'd5:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
      4'd6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
      4'd7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      4'd8:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
      4'd9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      4'd10: e.reg_write = 1'b1;
      4'd11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic out_t snap();
    out_t o;
    o.st         = bus.state;
    o.pc_en      = bus.pc_en;
    o.ir_write   = bus.ir_write;
    o.mem_write  = bus.mem_write;
    o.reg_write  = bus.reg_write;
    o.iord       = bus.iord;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_dst    = bus.reg_dst;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_op     = bus.alu_op;
    o.pc_src     = bus.pc_src;
    o.illegal_op = bus.illegal_op;
    return o;
  endfunction

  // Drive one cycle's inputs (just after a rising edge), push the expected
  // outputs, and advance to the falling edge where the caller samples.
  task automatic drive(input logic [3:0] st, input logic [5:0] op,
                       input logic z, input logic mr);
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    sb.push_back(model(st, op, z, mr, reset));
    @(negedge clk);
  endtask

  task automatic test_reset();
    out_t obs, exp;
    bus.opcode = OP_LW; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    sb.push_back(model(4'd0, OP_LW, 1'b1, 1'b1, 1'b1));
    @(negedge clk); // a rising edge has passed with reset high
    obs = snap(); exp = sb.pop_front(); checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", obs, exp);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lw();
    int st [6] = '{0, 1, 2, 3, 4, 0};
    int mr [6] = '{1, 1, 1, 1, 1, 0};
    out_t obs, exp;
    for (int i = 0; i < 6; i++) begin
      drive(4'(st[i]), OP_LW, 1'b0, 1'(mr[i]));
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL lw cycle %0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    int st [8] = '{0, 1, 2, 5, 5, 5, 5, 0};
    int mr [8] = '{1, 1, 1, 0, 0, 0, 1, 0};
    int n_wr = 0, n_rw = 0;
    out_t obs, exp;
    for (int i = 0; i < 8; i++) begin
      drive(4'(st[i]), OP_SW, 1'b0, 1'(mr[i]));
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs.mem_write) n_wr++;
      if (obs.reg_write) n_rw++;
      if (obs !== exp) begin
        errors++; $display("FAIL sw_wait cycle %0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_wr != 4) begin
      errors++; $display("FAIL sw_wait mem_write cycles: got %0d expected 4", n_wr);
    end
    checks++;
    if (n_rw != 0) begin
      errors++; $display("FAIL sw_wait reg_write cycles: got %0d expected 0", n_rw);
    end
  endtask

  task automatic test_beq(input logic z);
    int st [4] = '{0, 1, 8, 0};
    int mr [4] = '{1, 1, 1, 0};
    out_t obs, exp;
    for (int i = 0; i < 4; i++) begin
      drive(4'(st[i]), OP_BEQ, z, 1'(mr[i]));
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL beq z=%0d cycle %0d: got %h expected %h", z, i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    int st [4] = '{0, 1, 11, 0};
    int mr [4] = '{1, 1, 1, 0};
    out_t obs, exp;
    for (int i = 0; i < 4; i++) begin
      drive(4'(st[i]), OP_J, 1'b0, 1'(mr[i]));
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL jump cycle %0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
    int st [5] = '{0, 1, 9, 10, 0};
    int mr [5] = '{1, 1, 1, 1, 0};
    out_t obs, exp;
    for (int i = 0; i < 5; i++) begin
      drive(4'(st[i]), OP_ADDI, 1'b0, 1'(mr[i]));
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL addi cycle %0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    int st [3] = '{0, 1, 0};
    int mr [3] = '{1, 1, 0};
    int n_ill = 0;
    out_t obs, exp;
    for (int i = 0; i < 3; i++) begin
      drive(4'(st[i]), OP_BAD, 1'b1, 1'(mr[i]));
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs.illegal_op) n_ill++;
      if (obs !== exp) begin
        errors++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_ill != 1) begin
      errors++; $display("FAIL illegal pulse count: got %0d expected 1", n_ill);
    end
  endtask

  task automatic test_async_reset();
    int st_a [4] = '{0, 1, 2, 5};
    int mr_a [4] = '{1, 1, 1, 0};
    int st_b [5] = '{0, 1, 6, 7, 0};
    int mr_b [5] = '{1, 1, 1, 1, 0};
    out_t obs, exp;
    for (int i = 0; i < 4; i++) begin
      drive(4'(st_a[i]), OP_SW, 1'b0, 1'(mr_a[i]));
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL async_rst sw cycle %0d: got %h expected %h", i, obs, exp);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    // In MEMWR with mem_write high, halfway to the next rising edge.
    #2 reset = 1'b1;
    sb.push_back(model(4'd0, OP_SW, 1'b0, 1'b0, 1'b1));
    #1;
    obs = snap(); exp = sb.pop_front(); checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL async_rst immediate: got %h expected %h", obs, exp);
    end
    @(posedge clk); #1;
    sb.push_back(model(4'd0, OP_SW, 1'b0, 1'b1, 1'b1));
    bus.mem_ready = 1'b1;
    #1;
    obs = snap(); exp = sb.pop_front(); checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL async_rst held: got %h expected %h", obs, exp);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'(st_b[i]), OP_R, 1'b1, 1'(mr_b[i]));
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL async_rst restart cycle %0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // R, addi, j, lw back to back; mem_ready and zero are randomised in every
  // state that must not sample them.
  task automatic test_back_to_back();
    int         st [19] = '{0, 1, 6, 7,  0, 1, 9, 10,  0, 1, 11,
                            0, 0, 1, 2, 3, 3, 4, 0};
    logic [5:0] op [19] = '{OP_R, OP_R, OP_R, OP_R,
                            OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                            OP_J, OP_J, OP_J,
                            OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW};
    int         mr [19] = '{1, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0,
                            0, 1, 0, 0, 0, 1, 0, 0};
    logic m, z;
    out_t obs, exp;
    for (int i = 0; i < 19; i++) begin
      z = 1'($urandom_range(1, 0));
      if (st[i] inside {0, 3, 5}) m = 1'(mr[i]);
      else                        m = 1'($urandom_range(1, 0));
      drive(4'(st[i]), op[i], z, m);
      obs = snap(); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL b2b cycle %0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump();
    test_addi();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
